// File: rtl/fw_ram_scrub.sv
// ---------------------------------------------------------------------------
// fw_ram_scrub
//
// Purpose:
//   Sits between the CPU memory mux and the FW RAM port. After reset, and on
//   request, it overwrites every FW RAM word with FILL, one word per cycle.
//   It stalls CPU accesses until the overwrite has finished, so no firmware
//   data survives a reset or a scrub. Outside a scrub, CPU accesses pass
//   straight through to the RAM combinationally.
//
// Ports:
//   clk             in   1   system clock
//   reset           in   1   synchronous reset, active high
//   fw_app_mode     in   1   1 = app mode (FW RAM locked)
//   scrub_start     in   1   one-cycle scrub request (honoured only in IDLE)
//   scrub_busy      out  1   high while the scrub is writing
//   scrub_done      out  1   one-cycle pulse after the last word is written
//   scrub_err       out  1   sticky; app mode was seen during a scrub
//   cpu_cs          in   1   CPU request, held until cpu_ready
//   cpu_we          in   4   CPU byte write enables
//   cpu_address     in   AW  CPU word address
//   cpu_write_data  in   32  CPU write data
//   cpu_read_data   out  32  read data returned to the CPU
//   cpu_ready       out  1   CPU access complete
//   ram_cs          out  1   chip select to FW RAM
//   ram_we          out  4   byte write enables to FW RAM
//   ram_address     out  AW  word address to FW RAM
//   ram_write_data  out  32  write data to FW RAM
//   ram_read_data   in   32  read data from FW RAM
//   ram_ready       in   1   FW RAM ready, registered copy of ram_cs
// ---------------------------------------------------------------------------
module fw_ram_scrub #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10,
  parameter logic [31:0] FILL  = 32'h0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fw_app_mode,
  input  logic          scrub_start,
  output logic          scrub_busy,
  output logic          scrub_done,
  output logic          scrub_err,
  input  logic          cpu_cs,
  input  logic [3:0]    cpu_we,
  input  logic [AW-1:0] cpu_address,
  input  logic [31:0]   cpu_write_data,
  output logic [31:0]   cpu_read_data,
  output logic          cpu_ready,
  output logic          ram_cs,
  output logic [3:0]    ram_we,
  output logic [AW-1:0] ram_address,
  output logic [31:0]   ram_write_data,
  input  logic [31:0]   ram_read_data,
  input  logic          ram_ready
);

  typedef enum logic {
    SCRUB = 1'b0,
    IDLE  = 1'b1
  } state_t;

  // The counter never wraps into a second pass: the exit test looks at the
  // last address rather than relying on overflow.
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        state;
  logic [AW-1:0] addr_cnt;
  logic          cpu_owned_q;
  logic          scrub_done_q;
  logic          scrub_err_q;
  logic          start_take;

  // A scrub request is accepted only from IDLE and only outside app mode.
  // When accepted it takes priority over a CPU request in the same cycle.
  assign start_take = (state == IDLE) && scrub_start && !fw_app_mode && !reset;

  // Main FSM. cpu_owned_q remembers whether the previous RAM access came
  // from the CPU, so acks for scrub writes never reach the CPU side.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= SCRUB;
      addr_cnt     <= '0;
      cpu_owned_q  <= 1'b0;
      scrub_done_q <= 1'b0;
      scrub_err_q  <= 1'b0;
    end else begin
      scrub_done_q <= 1'b0;
      case (state)
        SCRUB: begin
          cpu_owned_q <= 1'b0;
          addr_cnt    <= addr_cnt + 1'b1;
          if (fw_app_mode) begin
            scrub_err_q <= 1'b1;
          end
          if (addr_cnt == LAST_ADDR) begin
            state        <= IDLE;
            scrub_done_q <= 1'b1;
          end
        end
        IDLE: begin
          if (start_take) begin
            state       <= SCRUB;
            addr_cnt    <= '0;
            cpu_owned_q <= 1'b0;
          end else begin
            cpu_owned_q <= cpu_cs;
          end
        end
        default: begin
          state <= SCRUB;
        end
      endcase
    end
  end

  // RAM port mux: scrub writes while scrubbing, CPU pass-through in IDLE.
  // Nothing is driven to the RAM during a reset cycle, so the scrub count
  // starts cleanly on the cycle after reset.
  always_comb begin
    ram_cs         = 1'b0;
    ram_we         = 4'h0;
    ram_address    = '0;
    ram_write_data = 32'h0;
    if (!reset) begin
      if (state == SCRUB) begin
        ram_cs         = 1'b1;
        ram_we         = 4'hf;
        ram_address    = addr_cnt;
        ram_write_data = FILL;
      end else begin
        ram_cs         = cpu_cs & ~start_take;
        ram_we         = cpu_we;
        ram_address    = cpu_address;
        ram_write_data = cpu_write_data;
      end
    end
  end

  // Status and CPU return path. Reset forces the idle-looking CPU view and
  // a busy indication even before the first reset edge has been seen.
  assign scrub_busy    = reset | (state == SCRUB);
  assign scrub_done    = scrub_done_q & ~reset;
  assign scrub_err     = scrub_err_q;
  assign cpu_ready     = ram_ready & cpu_owned_q & ~reset;
  assign cpu_read_data = (cpu_owned_q && !reset) ? ram_read_data : 32'h0;

endmodule

// File: tb/tb_fw_ram_scrub.sv
// ---------------------------------------------------------------------------
// tb_fw_ram_scrub
//
// Purpose:
//   Self-checking bench for fw_ram_scrub. Contains a behavioural FW RAM with
//   one-cycle ready, a scoreboard of expected CPU completions, and a monitor
//   that checks every scrub write and every CPU completion.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fw_ram_scrub;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          fw_app_mode = 1'b0;
  logic          scrub_start = 1'b0;
  logic          scrub_busy;
  logic          scrub_done;
  logic          scrub_err;
  logic          cpu_cs = 1'b0;
  logic [3:0]    cpu_we = 4'h0;
  logic [AW-1:0] cpu_address = '0;
  logic [31:0]   cpu_write_data = 32'h0;
  logic [31:0]   cpu_read_data;
  logic          cpu_ready;
  logic          ram_cs;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_address;
  logic [31:0]   ram_write_data;
  logic [31:0]   ram_read_data = 32'h0;
  logic          ram_ready = 1'b0;

  logic [31:0]   mem [0:DEPTH-1];
  logic          preloadReq = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int scrubIdx = 0;
  int doneCount = 0;

  typedef struct {
    bit          chkData;
    logic [31:0] data;
    int          readyCycle;
  } exp_t;

  exp_t expQ[$];

  fw_ram_scrub #(
    .DEPTH(DEPTH),
    .AW(AW),
    .FILL(32'h0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fw_app_mode(fw_app_mode),
    .scrub_start(scrub_start),
    .scrub_busy(scrub_busy),
    .scrub_done(scrub_done),
    .scrub_err(scrub_err),
    .cpu_cs(cpu_cs),
    .cpu_we(cpu_we),
    .cpu_address(cpu_address),
    .cpu_write_data(cpu_write_data),
    .cpu_read_data(cpu_read_data),
    .cpu_ready(cpu_ready),
    .ram_cs(ram_cs),
    .ram_we(ram_we),
    .ram_address(ram_address),
    .ram_write_data(ram_write_data),
    .ram_read_data(ram_read_data),
    .ram_ready(ram_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
  end

  // Behavioural FW RAM: ready one cycle after cs, read-before-write, byte
  // enables honoured. The preload fills every word with a recognisable value.
  always @(posedge clk) begin
    ram_ready <= ram_cs;
    if (preloadReq) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 32'hDEADBEEF;
      end
    end else if (ram_cs) begin
      ram_read_data <= mem[ram_address];
      for (int b = 0; b < 4; b++) begin
        if (ram_we[b]) begin
          mem[ram_address][8*b +: 8] <= ram_write_data[8*b +: 8];
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic applyStimulus(input logic cs, input logic [3:0] we, input logic [AW-1:0] addr,
                               input logic [31:0] data, input logic start, input logic app);
    cpu_cs         = cs;
    cpu_we         = we;
    cpu_address    = addr;
    cpu_write_data = data;
    scrub_start    = start;
    fw_app_mode    = app;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the caller on the negedge of the first IDLE cycle when seen.
  task automatic waitDone(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 1200 && !seen; i++) begin
      @(negedge clk);
      if (scrub_done === 1'b1) begin
        seen = 1'b1;
      end
    end
    if (!seen) begin
      checkOutput("scrub_done_timeout", scrub_done, 1);
    end
  endtask

  task automatic countNonFill(output int nz);
    nz = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i] !== 32'h0) begin
        nz++;
      end
    end
  endtask

  // Monitor: pops the scoreboard on every CPU completion and checks every
  // scrub cycle's RAM write, plus the length and end pulse of each scrub.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        scrubIdx = 0;
      end else begin
        if (cpu_ready === 1'b1) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_ready", cpu_ready, 0);
          end else begin
            e = expQ.pop_front();
            checkOutput("ready_cycle", cyc, e.readyCycle);
            if (e.chkData) begin
              checkOutput("read_data", cpu_read_data, e.data);
            end
          end
        end
        if (scrub_busy === 1'b1) begin
          checkOutput("scrub_ram_cs", ram_cs, 1);
          checkOutput("scrub_ram_we", ram_we, 4'hf);
          checkOutput("scrub_ram_addr", ram_address, scrubIdx);
          checkOutput("scrub_ram_data", ram_write_data, 32'h0);
          checkOutput("scrub_cpu_stall", cpu_ready, 0);
          scrubIdx++;
        end else if (scrub_done !== 1'b0 || scrubIdx != 0) begin
          checkOutput("scrub_done_pulse", scrub_done, 1);
          checkOutput("scrub_length", scrubIdx, DEPTH);
          doneCount++;
          scrubIdx = 0;
        end
      end
    end
  end

  initial begin
    bit seen;
    int nz;

    // Reset with preload of stale data into the RAM model.
    preloadReq = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    preloadReq = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy", scrub_busy, 1);
    checkOutput("rst_done", scrub_done, 0);
    checkOutput("rst_ready", cpu_ready, 0);
    checkOutput("rst_rdata", cpu_read_data, 32'h0);
    checkOutput("rst_err", scrub_err, 0);
    stepCycle();
    reset = 1'b0;

    // CPU read of addr 5 held during the power-on scrub.
    repeat (10) stepCycle();
    applyStimulus(1'b1, 4'h0, 10'd5, 32'h0, 1'b0, 1'b0);
    waitDone(seen);
    if (seen) begin
      checkOutput("held_fwd_cs", ram_cs, 1);
      checkOutput("held_fwd_addr", ram_address, 10'd5);
      checkOutput("held_fwd_we", ram_we, 4'h0);
      expQ.push_back('{chkData: 1'b1, data: 32'h0, readyCycle: cyc + 1});
    end
    stepCycle();
    applyStimulus(1'b0, 4'h0, '0, 32'h0, 1'b0, 1'b0);
    countNonFill(nz);
    checkOutput("ram_all_fill_1", nz, 0);
    stepCycle();

    // Byte-enabled write then readback in IDLE.
    applyStimulus(1'b1, 4'h3, 10'd7, 32'h12345678, 1'b0, 1'b0);
    expQ.push_back('{chkData: 1'b0, data: 32'h0, readyCycle: cyc + 1});
    stepCycle();
    applyStimulus(1'b0, 4'h0, '0, 32'h0, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 4'h0, 10'd7, 32'h0, 1'b0, 1'b0);
    expQ.push_back('{chkData: 1'b1, data: 32'h00005678, readyCycle: cyc + 1});
    stepCycle();
    applyStimulus(1'b0, 4'h0, '0, 32'h0, 1'b0, 1'b0);
    stepCycle();
    stepCycle();

    // Read forwarded at N, scrub requested at N+1 while cs still held.
    applyStimulus(1'b1, 4'h0, 10'd7, 32'h0, 1'b0, 1'b0);
    expQ.push_back('{chkData: 1'b1, data: 32'h00005678, readyCycle: cyc + 1});
    stepCycle();
    applyStimulus(1'b1, 4'h0, 10'd7, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("start_wins_cs", ram_cs, 0);
    stepCycle();
    applyStimulus(1'b0, 4'h0, '0, 32'h0, 1'b0, 1'b0);
    waitDone(seen);
    stepCycle();
    countNonFill(nz);
    checkOutput("ram_all_fill_2", nz, 0);

    // Scrub with app mode, then reset at address 500.
    applyStimulus(1'b0, 4'h0, '0, 32'h0, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 4'h0, '0, 32'h0, 1'b0, 1'b0);
    repeat (20) stepCycle();
    fw_app_mode = 1'b1;
    repeat (3) stepCycle();
    fw_app_mode = 1'b0;
    @(negedge clk);
    checkOutput("err_set_1", scrub_err, 1);
    seen = 1'b0;
    for (int i = 0; i < 1200 && !seen; i++) begin
      @(negedge clk);
      if (scrub_busy === 1'b1 && ram_address === 10'd500) begin
        seen = 1'b1;
      end
    end
    if (!seen) begin
      checkOutput("addr500_timeout", ram_address, 10'd500);
    end
    stepCycle();
    reset = 1'b1;
    stepCycle();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("err_cleared", scrub_err, 0);
    checkOutput("restart_addr0", ram_address, 10'd0);
    repeat (100) stepCycle();
    fw_app_mode = 1'b1;
    repeat (2) stepCycle();
    fw_app_mode = 1'b0;
    @(negedge clk);
    checkOutput("err_set_2", scrub_err, 1);
    waitDone(seen);
    checkOutput("err_sticky", scrub_err, 1);
    stepCycle();

    // Scrub request ignored in app mode.
    applyStimulus(1'b0, 4'h0, '0, 32'h0, 1'b1, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 4'h0, '0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("app_blocks_start", scrub_busy, 0);
    end
    stepCycle();

    checkOutput("done_count", doneCount, 3);
    checkOutput("queue_drained", expQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
